// File: rtl/fp_lzc_pkg.sv
// fp_lzc_pkg: shared defaults, FSM states and index type for the shared leading-one detector
package fp_lzc_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SEG_W = 8;
  localparam int IDX_W = $clog2(DEF_DATA_W) + 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} lzc_state_t;
  typedef logic [IDX_W-1:0] lzc_idx_t;
  localparam lzc_idx_t LZC_NONE = '1;
endpackage

// File: rtl/lzc_seg_enc.sv
// lzc_seg_enc: combinational highest-one encoder for one SEG_W-bit segment
module lzc_seg_enc #(
  parameter int SEG_W = 8,
  localparam int LW = SEG_W > 1 ? $clog2(SEG_W) : 1
) (
  input  logic [SEG_W-1:0] seg_bits,
  output logic [LW-1:0]    loc,
  output logic             hit
);
  always_comb begin
    loc = '0;
    for (int i = 0; i < SEG_W; i++) if (seg_bits[i]) loc = LW'(i);
  end
  assign hit = |seg_bits;
endmodule

// File: rtl/lzc_share_ctrl.sv
// lzc_share_ctrl: round-robin shared segmented leading-one detector (LZC_EARLY_EXIT_EN stops at first hit)
module lzc_share_ctrl
  import fp_lzc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEG_W = DEF_SEG_W,
  localparam int NSEG = DATA_W / SEG_W,
  localparam int IDX_W = $clog2(DATA_W) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [1:0]          req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [IDX_W-1:0]    rsp_idx,
  output logic                rsp_zero,
  output logic                busy
);
  localparam int SW = NSEG > 1 ? $clog2(NSEG) : 1;
  localparam int LW = SEG_W > 1 ? $clog2(SEG_W) : 1;
`ifdef LZC_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  lzc_state_t        state;
  logic [DATA_W-1:0] op;
  logic [SW-1:0]     seg;
  logic              hit, rr_ptr, seg_hit, scan_end;
  logic [LW-1:0]     loc;
  logic [1:0]        gnt;
  logic [SEG_W-1:0]  seg_bits;
  logic [IDX_W-1:0]  seg_idx;
  always_comb begin
    gnt[0] = req_valid[0] && (!rr_ptr || !req_valid[1]);
    gnt[1] = req_valid[1] && (rr_ptr || !req_valid[0]);
  end
  assign req_ready = (state == IDLE && !reset) ? gnt : 2'b00;
  assign seg_bits = op[seg*SEG_W +: SEG_W];
  assign seg_idx = IDX_W'(seg) * IDX_W'(SEG_W) + IDX_W'(loc);
  assign scan_end = (seg == '0) || (EARLY && seg_hit);
  lzc_seg_enc #(.SEG_W(SEG_W)) u_enc (
    .seg_bits(seg_bits),
    .loc(loc),
    .hit(seg_hit)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      seg <= '0;
      hit <= 1'b0;
      rr_ptr <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_idx <= '1;
      rsp_zero <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          op <= gnt[1] ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
          rsp_id <= gnt[1];
          seg <= SW'(NSEG - 1);
          hit <= 1'b0;
          rsp_idx <= '1;
          busy <= 1'b1;
          state <= SCAN;
        end
        SCAN: begin
          // only the first nonzero segment (scanning MSB-first) holds the answer
          if (seg_hit && !hit) begin
            rsp_idx <= seg_idx;
            hit <= 1'b1;
          end
          if (scan_end) begin
            rsp_zero <= !(hit || seg_hit);
            rsp_valid <= 1'b1;
            state <= DONE;
          end else seg <= seg - SW'(1);
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy <= 1'b0;
          rr_ptr <= !rsp_id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
